// File: rtl/amber48_pkg.sv
// amber48_pkg: shared amber48 widths, constants and data-memory types
package amber48_pkg;

    localparam int XLEN             = 48;
    localparam int BAU_BYTES        = 6;
    localparam int DMEM_LATENCY_MAX = 15;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } amber48_dmem_state_e;

endpackage

// File: rtl/amber48_dmem_ram.sv
// amber48_dmem_ram: single-port synchronous RAM with registered read
module amber48_dmem_ram
  import amber48_pkg::*;
#(
  parameter int    WIDTH     = XLEN,
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = "",
  localparam int   AW        = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else rdata_q <= mem_q[addr_i];
    end
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/amber48_dmem.sv
// amber48_dmem: load/store responder with programmable wait states, fault checking and gated outputs
module amber48_dmem
    import amber48_pkg::*;
#(
    parameter int                      XLEN      = amber48_pkg::XLEN,
    parameter int                      DEPTH     = 1024,
    parameter logic [XLEN-1:0]         BASE_ADDR = '0,
    parameter int unsigned             LATENCY   = 1,
    parameter string                   INIT_FILE = ""
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clk_en_i,
    input  logic            dmem_req_i,
    input  logic            dmem_we_i,
    input  logic [XLEN-1:0] dmem_addr_i,
    input  logic [XLEN-1:0] dmem_wdata_i,
    output logic [XLEN-1:0] dmem_rdata_o,
    output logic            dmem_ready_o,
    output logic            dmem_trap_o
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = $clog2(DMEM_LATENCY_MAX + 1);
    localparam logic [XLEN-1:0] SPAN     = XLEN'(DEPTH * BAU_BYTES);
    localparam logic [XLEN-1:0] BAU      = XLEN'(BAU_BYTES);
    localparam logic [CW-1:0]   CNT_INIT = CW'(LATENCY - 1);

    amber48_dmem_state_e state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [AW-1:0]   idx_q, idx_d;

    logic [XLEN-1:0] off;
    logic            fault_in;
    logic [AW-1:0]   idx_in;
    logic            step;
    logic            ram_en;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [XLEN-1:0] ram_rdata;

    // offset from the window base; below-base addresses wrap and are caught by the compare
    assign step     = clk_en_i & ~rst_i;
    assign off      = dmem_addr_i - BASE_ADDR;
    assign fault_in = (dmem_addr_i < BASE_ADDR) || (off >= SPAN) || ((off % BAU) != '0);
    assign idx_in   = AW'(off / BAU);

    // request capture, wait-state countdown and abort handling
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        fault_d = fault_q;
        case (state_q)
            DMEM_IDLE: begin
                if (dmem_req_i) begin
                    we_d    = dmem_we_i;
                    wdata_d = dmem_wdata_i;
                    idx_d   = idx_in;
                    fault_d = fault_in;
                    cnt_d   = CNT_INIT;
                    state_d = (CNT_INIT == '0) ? DMEM_RESP : DMEM_WAIT;
                end
            end
            DMEM_WAIT: begin
                if (!dmem_req_i) state_d = DMEM_IDLE;
                else if (cnt_q == CW'(1)) state_d = DMEM_RESP;
                else cnt_d = cnt_q - CW'(1);
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    // control state advances only on enabled edges; reset wins regardless of the enable
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
            wdata_q <= '0;
            idx_q   <= '0;
        end else if (clk_en_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            fault_q <= fault_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
        end
    end

    // the store commits as RESP ends; the read is launched on entry to RESP so data lines up with ready
    assign ram_we   = step && (state_q == DMEM_RESP) && we_q && !fault_q;
    assign ram_en   = ram_we || (step && (state_q != DMEM_RESP) && (state_d == DMEM_RESP) && !fault_d);
    assign ram_addr = (state_q == DMEM_IDLE) ? idx_in : idx_q;

    amber48_dmem_ram #(
        .WIDTH     (XLEN),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk_i   (clk_i),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign dmem_ready_o = (state_q == DMEM_RESP);
    assign dmem_trap_o  = dmem_ready_o & fault_q;
    assign dmem_rdata_o = (dmem_ready_o && !fault_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_amber48_dmem.sv
// tb_amber48_dmem: randomized and directed checks of two amber48_dmem configurations against a word-array model
module tb_amber48_dmem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic        req [2];
    logic        we [2];
    logic [47:0] addr [2];
    logic [47:0] wdata [2];
    logic [47:0] rdata [2];
    logic        ready [2];
    logic        trap [2];

    int          lat [2]   = '{1, 3};
    int          depth [2] = '{1024, 64};
    longint      base [2]  = '{0, 96};
    logic [47:0] mem [2][1024];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    amber48_dmem #(.DEPTH(1024), .BASE_ADDR(48'd0), .LATENCY(1)) u_l1 (
        .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en),
        .dmem_req_i(req[0]), .dmem_we_i(we[0]), .dmem_addr_i(addr[0]), .dmem_wdata_i(wdata[0]),
        .dmem_rdata_o(rdata[0]), .dmem_ready_o(ready[0]), .dmem_trap_o(trap[0])
    );

    amber48_dmem #(.DEPTH(64), .BASE_ADDR(48'd96), .LATENCY(3)) u_l3 (
        .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en),
        .dmem_req_i(req[1]), .dmem_we_i(we[1]), .dmem_addr_i(addr[1]), .dmem_wdata_i(wdata[1]),
        .dmem_rdata_o(rdata[1]), .dmem_ready_o(ready[1]), .dmem_trap_o(trap[1])
    );

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic idle_checks(input int k, input string tag);
        check({tag, " ready"}, 48'(ready[k]), 48'd0);
        check({tag, " trap"}, 48'(trap[k]), 48'd0);
        check({tag, " rdata"}, rdata[k], 48'd0);
    endtask

    // one request on port k; drop>0 lowers req at the start of that cycle, hold>0 freezes the RESP cycle
    task automatic xfer(input int k, input logic w, input logic [47:0] a, input logic [47:0] d,
                        input int drop, input int hold);
        longint off;
        logic   flt;
        int     idx;
        off = longint'(a) - base[k];
        flt = (off < 0) || (off >= longint'(depth[k]) * 6) || (off % 6 != 0);
        idx = flt ? 0 : int'(off / 6);
        req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
        for (int c = 1; c <= lat[k] + 1; c++) begin
            @(posedge clk); #1;
            if (drop == 0 && c == lat[k]) begin
                for (int h = 0; h <= hold; h++) begin
                    if (h > 0) begin
                        @(posedge clk); #1;
                    end
                    check("resp ready", 48'(ready[k]), 48'd1);
                    check("resp trap", 48'(trap[k]), 48'(flt));
                    if (flt || !w) check("resp rdata", rdata[k], flt ? 48'd0 : mem[k][idx]);
                    clk_en = (h == hold);
                end
                req[k] = 1'b0;
            end else begin
                idle_checks(k, "quiet");
            end
            if (c == drop) req[k] = 1'b0;
        end
        if (!flt && w && drop == 0) mem[k][idx] = d;
    endtask

    function automatic logic [47:0] rnd48();
        return {16'($urandom), $urandom};
    endfunction

    initial begin
        int          k;
        int          sel;
        int          idx;
        logic        w;
        logic [47:0] a;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        idle_checks(0, "reset l1");
        idle_checks(1, "reset l3");
        rst = 1'b0;

        for (int j = 0; j < 2; j++)
            for (int i = 0; i < depth[j]; i++) xfer(j, 1'b1, 48'(base[j] + 6 * i), rnd48(), 0, 0);

        xfer(0, 1'b1, 48'd18, 48'h123456789ABC, 0, 0);
        xfer(0, 1'b0, 48'd18, 48'h0, 0, 0);
        check("store-load value", mem[0][3], 48'h123456789ABC);

        xfer(1, 1'b1, 48'd96 + 48'd12, 48'hA5A5A5A5A5A5, 0, 0);
        xfer(1, 1'b0, 48'd96 + 48'd12, 48'h0, 0, 0);

        xfer(0, 1'b1, 48'd6144, rnd48(), 0, 0);
        xfer(0, 1'b0, 48'd6138, 48'h0, 0, 0);
        xfer(0, 1'b0, 48'd7, 48'h0, 0, 0);
        xfer(1, 1'b0, 48'd95, 48'h0, 0, 0);
        xfer(1, 1'b0, 48'd96 + 48'd384, 48'h0, 0, 0);

        xfer(1, 1'b1, 48'd96 + 48'd30, 48'hFFFFFFFFFFFF, 2, 0);
        xfer(1, 1'b1, 48'd96 + 48'd30, 48'hFFFFFFFFFFFF, 1, 0);
        xfer(1, 1'b0, 48'd96 + 48'd30, 48'h0, 0, 0);

        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 48'd96 + 48'd42; wdata[1] = 48'h0BADC0DE0BAD;
        @(posedge clk); #1;
        idle_checks(1, "pre-reset");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req[1] = 1'b0;
        idle_checks(1, "post-reset");
        repeat (4) begin
            @(posedge clk); #1;
            idle_checks(1, "after reset");
        end
        xfer(1, 1'b0, 48'd96 + 48'd42, 48'h0, 0, 0);

        xfer(0, 1'b0, 48'd60, 48'h0, 0, 5);
        xfer(0, 1'b1, 48'd66, rnd48(), 0, 5);
        xfer(1, 1'b0, 48'd96 + 48'd6, 48'h0, 0, 5);

        for (int t = 0; t < 400; t++) begin
            k   = int'($urandom_range(0, 1));
            w   = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            idx = int'($urandom_range(0, depth[k] - 1));
            a   = 48'(base[k] + 6 * idx);
            if (sel == 0) a = 48'(base[k] + 6 * depth[k] + 6 * int'($urandom_range(0, 3)));
            if (sel == 1) a = a + 48'($urandom_range(1, 5));
            if (sel == 2 && k == 1) a = 48'(base[k] - longint'($urandom_range(1, 96)));
            if (sel == 3) a = 48'(base[k] + 6 * (depth[k] - 1));
            xfer(k, w, a, rnd48(), (sel == 4 && lat[k] > 1) ? int'($urandom_range(1, lat[k] - 1)) : 0, 0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                idle_checks(k, "gap");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
